// File: rtl/dsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pkg
// Description : Shared constants and helpers for the DSP slice pipeline regs.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_pkg;

    localparam int DEPTH_MAX = 8;

    // Width of the latency tap selector: enough to encode 0..depth, never 0.
    function automatic int lat_w(input int depth);
        return ($clog2(depth + 1) < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic bit depth_ok(input int depth);
        return (depth >= 0) && (depth <= DEPTH_MAX);
    endfunction

endpackage : dsp_pkg
`default_nettype wire

// File: rtl/dsp_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pipe_stage
// Description : One pipeline register stage: data word plus valid tag.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_pipe_stage #(
    parameter int            DW      = 18,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sclr,
    input  logic          ce,
    input  logic          d_valid,
    input  logic [DW-1:0] d_data,
    output logic          q_valid,
    output logic [DW-1:0] q_data,
    output logic          nxt_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_valid <= 1'b0;
            q_data  <= RST_VAL;
        end else if (sclr) begin
            q_valid <= 1'b0;
            q_data  <= RST_VAL;
        end else if (ce) begin
            q_valid <= d_valid;
            q_data  <= d_data;
        end
    end

    // Next-state valid, exported so the top can register occupancy in step.
    assign nxt_valid = sclr ? 1'b0 : (ce ? d_valid : q_valid);

endmodule : dsp_pipe_stage
`default_nettype wire

// File: rtl/dsp_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_pipe_reg
// Description : Multi-channel DEPTH-stage delay line with valid tag and tap mux.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_pipe_reg
    import dsp_pkg::*;
#(
    parameter int               WIDTH    = 18,
    parameter int               CHANNELS = 1,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               LW       = lat_w(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      sclr,
    input  logic [LW-1:0]             lat_sel,
    input  logic                      in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [3:0]                occupancy
);

    localparam int                DW        = CHANNELS * WIDTH;
    localparam int                NV        = (DEPTH > 0) ? DEPTH : 1;
    localparam logic [DW-1:0]     RST_WORD  = {CHANNELS{RST_VAL}};
    localparam logic [LW-1:0]     DEPTH_SEL = LW'(DEPTH);

    generate
        if (!depth_ok(DEPTH)) begin : g_depth_bad
            $error("dsp_pipe_reg: DEPTH %0d outside 0..%0d", DEPTH, DEPTH_MAX);
        end
    endgenerate

    // Index 0 is the unregistered input; index k is stage k.
    logic [DW-1:0] tap_data [0:DEPTH];
    logic [DEPTH:0] tap_valid;
    logic [NV-1:0]  nxt_valid;
    logic [LW-1:0]  sel_eff;

    assign tap_data[0]  = in_data;
    assign tap_valid[0] = in_valid;

    generate
        for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
            dsp_pipe_stage #(
                .DW      (DW),
                .RST_VAL (RST_WORD)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .sclr      (sclr),
                .ce        (ce),
                .d_valid   (tap_valid[k-1]),
                .d_data    (tap_data[k-1]),
                .q_valid   (tap_valid[k]),
                .q_data    (tap_data[k]),
                .nxt_valid (nxt_valid[k-1])
            );
        end
    endgenerate

    assign sel_eff = (lat_sel > DEPTH_SEL) ? DEPTH_SEL : lat_sel;

    always_comb begin
        out_data  = tap_data[0];
        out_valid = tap_valid[0];
        for (int k = 1; k <= DEPTH; k++) begin
            if (sel_eff == LW'(k)) begin
                out_data  = tap_data[k];
                out_valid = tap_valid[k];
            end
        end
    end

    generate
        if (DEPTH == 0) begin : g_occ_none
            assign nxt_valid = '0;
            assign occupancy = 4'd0;
        end else begin : g_occ
            logic [3:0] occ_nxt;

            always_comb begin
                occ_nxt = 4'd0;
                for (int k = 0; k < DEPTH; k++) begin
                    occ_nxt = occ_nxt + {3'b000, nxt_valid[k]};
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    occupancy <= 4'd0;
                end else begin
                    occupancy <= occ_nxt;
                end
            end
        end
    endgenerate

endmodule : dsp_pipe_reg
`default_nettype wire

// File: tb/tb_dsp_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_pipe_reg
// Description : Self-checking bench for dsp_pipe_reg (DEPTH 3, 2 and 0 instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_pipe_reg;

    localparam int               W     = 18;
    localparam int               DW    = 36;
    localparam logic [W-1:0]     RV    = 18'd5;
    localparam logic [DW-1:0]    RPAIR = {RV, RV};

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
    } samp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ce = 1'b0;
    logic          sclr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    lat = 2'd0;
    logic          zlat = 1'b0;

    logic          m_valid, t_valid, z_valid;
    logic [DW-1:0] m_data, t_data, z_data;
    logic [3:0]    m_occ, t_occ, z_occ;

    samp_t      sb[$];
    samp_t      sb2[$];
    samp_t      last_m, last_t;
    logic [2:0] vhist;
    int         n_tests = 0;
    int         n_fail = 0;
    int         val = 1;

    always #5 clk = ~clk;

    dsp_pipe_reg #(.WIDTH(W), .CHANNELS(2), .DEPTH(3), .RST_VAL(RV)) u_dut (
        .clk(clk), .rst(rst), .ce(ce), .sclr(sclr), .lat_sel(lat),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(m_valid), .out_data(m_data), .occupancy(m_occ)
    );

    dsp_pipe_reg #(.WIDTH(W), .CHANNELS(2), .DEPTH(2), .RST_VAL(RV)) u_d2 (
        .clk(clk), .rst(rst), .ce(ce), .sclr(sclr), .lat_sel(lat),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(t_valid), .out_data(t_data), .occupancy(t_occ)
    );

    dsp_pipe_reg #(.WIDTH(W), .CHANNELS(2), .DEPTH(0), .RST_VAL(RV)) u_d0 (
        .clk(clk), .rst(rst), .ce(ce), .sclr(sclr), .lat_sel(zlat),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(z_valid), .out_data(z_data), .occupancy(z_occ)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pc(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    task automatic check_d0();
        chk("d0_data", z_data, in_data);
        chk("d0_valid", z_valid, in_valid);
        chk("d0_occ", z_occ, 0);
    endtask

    // Prime the scoreboards with the reset entries visible at tap k after a clear.
    task automatic reset_models(input int k);
        sb.delete();
        sb2.delete();
        vhist = '0;
        for (int i = 1; i < k; i++) sb.push_back('{v: 1'b0, d: RPAIR});
        for (int i = 1; i < ((k > 2) ? 2 : k); i++) sb2.push_back('{v: 1'b0, d: RPAIR});
    endtask

    task automatic clear_pipe(input int k);
        lat      = 2'(k);
        zlat     = lat[0];
        sclr     = 1'b1;
        ce       = 1'b0;
        in_valid = 1'b1;
        in_data  = {18'h3FFFF, 18'h3FFFF};
        @(posedge clk);
        #1;
        sclr = 1'b0;
        reset_models(k);
        chk("clr_occ", m_occ, 0);
        chk("clr_d2_occ", t_occ, 0);
        if (k > 0) begin
            chk("clr_data", m_data, RPAIR);
            chk("clr_valid", m_valid, 0);
        end
    endtask

    task automatic stream(input logic v, input int k);
        samp_t e;
        lat      = 2'(k);
        zlat     = lat[0];
        in_valid = v;
        in_data  = {W'(val) ^ 18'h2AAAA, W'(val)};
        val++;
        ce   = 1'b1;
        sclr = 1'b0;
        #1;
        check_d0();
        if (k == 0) begin
            chk("bypass_data", m_data, in_data);
            chk("bypass_valid", m_valid, in_valid);
        end
        @(posedge clk);
        #1;
        vhist = {vhist[1:0], v};
        if (k == 0) begin
            sb.delete();
            sb2.delete();
        end else begin
            sb.push_back('{v: v, d: in_data});
            sb2.push_back('{v: v, d: in_data});
            e = sb.pop_front();
            last_m = e;
            chk("tap_data", m_data, e.d);
            chk("tap_valid", m_valid, e.v);
            e = sb2.pop_front();
            last_t = e;
            chk("d2_clamp_data", t_data, e.d);
            chk("d2_clamp_valid", t_valid, e.v);
        end
        chk("occ", m_occ, pc(vhist));
        chk("d2_occ", t_occ, pc({1'b0, vhist[1:0]}));
    endtask

    initial begin
        // Asynchronous reset asserted between clock edges.
        in_data  = {18'h01234, 18'h00ABC};
        in_valid = 1'b1;
        lat      = 2'd2;
        #3;
        rst = 1'b1;
        #1;
        chk("rst_tap2_data", m_data, RPAIR);
        chk("rst_tap2_valid", m_valid, 0);
        chk("rst_occ", m_occ, 0);
        chk("rst_d2_data", t_data, RPAIR);
        lat = 2'd0;
        #1;
        chk("rst_bypass_data", m_data, in_data);
        chk("rst_bypass_valid", m_valid, in_valid);
        in_data = {18'h15555, 18'h0F0F0};
        #1;
        chk("rst_bypass_follow", m_data, in_data);
        check_d0();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency sweep over every tap.
        for (int k = 0; k <= 3; k++) begin
            clear_pipe(k);
            for (int i = 0; i < 6; i++) stream(1'b1, k);
        end

        // Clock-enable stall at the deepest tap.
        for (int i = 0; i < 4; i++) begin
            ce       = 1'b0;
            in_valid = 1'($urandom);
            in_data  = DW'({$urandom, $urandom});
            @(posedge clk);
            #1;
            chk("stall_data", m_data, last_m.d);
            chk("stall_valid", m_valid, last_m.v);
            chk("stall_d2_data", t_data, last_t.d);
            chk("stall_occ", m_occ, pc(vhist));
        end
        for (int i = 0; i < 4; i++) stream(1'b1, 3);

        // Clear beats ce and a valid input sample on the same edge.
        sclr     = 1'b1;
        ce       = 1'b1;
        in_valid = 1'b1;
        in_data  = {18'h0BEEF, 18'h0BEEF};
        @(posedge clk);
        #1;
        sclr = 1'b0;
        ce   = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            lat = 2'(k);
            #1;
            chk("sclr_tap_data", m_data, RPAIR);
            chk("sclr_tap_valid", m_valid, 0);
        end
        chk("sclr_occ", m_occ, 0);
        reset_models(3);
        for (int i = 0; i < 4; i++) stream(1'b1, 3);

        // Valid bubbles at tap 2.
        clear_pipe(2);
        stream(1'b1, 2);
        stream(1'b0, 2);
        stream(1'b1, 2);
        stream(1'b1, 2);
        stream(1'b0, 2);
        stream(1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_dsp_pipe_reg
`default_nettype wire
